avl_arbiter: RTL

Two-port request arbiter sitting directly upstream of the Avalon-MM bridge. Merges the instruction-fetch port and the data-memory port of the core into the single pulse-valid / ready memory request port the bridge consumes. Captures each port's one-cycle request into a one-deep pending slot, issues one transaction at a time and routes the response back to the owning port.

---
 rtl/avl_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/avl_arbiter.sv
// Two-port (instruction/data) request arbiter in front of the Avalon-MM bridge.
// Define AVL_ARB_ROUND_ROBIN_EN to replace fixed data priority with alternating tie-breaks.
module avl_arbiter (
    input  logic        clock,
    input  logic        reset,
    input  logic        imem_valid,
    input  logic [31:0] imem_addr,
    output logic [31:0] imem_rdata,
    output logic        imem_ready,
    input  logic        dmem_valid,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_rdata,
    output logic        dmem_ready,
    output logic        mem_valid,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    state_t      state, state_next;
    logic        ipend_vld, dpend_vld;
    logic [31:0] ipend_addr, dpend_addr, dpend_wdata;
    logic [3:0]  dpend_wstrb;
    logic        grant_i, grant_d;
    logic        tie_to_i;

`ifdef AVL_ARB_ROUND_ROBIN_EN
    logic last_grant_d;

    // Resets to "data", so the first tie after reset goes to instruction.
    always_ff @(posedge clock) begin
        if (!reset)       last_grant_d <= 1'b1;
        else if (grant_i) last_grant_d <= 1'b0;
        else if (grant_d) last_grant_d <= 1'b1;
    end

    assign tie_to_i = last_grant_d;
`else
    assign tie_to_i = 1'b0;
`endif

    // A valid while the slot is still occupied is a protocol violation and is dropped.
    always_ff @(posedge clock) begin
        if (!reset) begin
            ipend_vld  <= 1'b0;
            ipend_addr <= '0;
        end else if (imem_valid && !ipend_vld) begin
            ipend_vld  <= 1'b1;
            ipend_addr <= imem_addr;
        end else if (grant_i) begin
            ipend_vld  <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            dpend_vld   <= 1'b0;
            dpend_addr  <= '0;
            dpend_wdata <= '0;
            dpend_wstrb <= '0;
        end else if (dmem_valid && !dpend_vld) begin
            dpend_vld   <= 1'b1;
            dpend_addr  <= dmem_addr;
            dpend_wdata <= dmem_wdata;
            dpend_wstrb <= dmem_wstrb;
        end else if (grant_d) begin
            dpend_vld   <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant_i)      state_next = BUSY_I;
                else if (grant_d) state_next = BUSY_D;
            end
            BUSY_I, BUSY_D: if (mem_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        mem_valid  = 1'b0;
        mem_instr  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_wstrb  = '0;
        imem_ready = 1'b0;
        imem_rdata = '0;
        dmem_ready = 1'b0;
        dmem_rdata = '0;
        case (state)
            IDLE: begin
                if (ipend_vld && dpend_vld) begin
                    grant_i = tie_to_i;
                    grant_d = !tie_to_i;
                end else begin
                    grant_i = ipend_vld;
                    grant_d = dpend_vld;
                end
                if (grant_i) begin
                    mem_valid = 1'b1;
                    mem_instr = 1'b1;
                    mem_addr  = ipend_addr;
                end else if (grant_d) begin
                    mem_valid = 1'b1;
                    mem_addr  = dpend_addr;
                    mem_wdata = dpend_wdata;
                    mem_wstrb = dpend_wstrb;
                end
            end
            BUSY_I: if (mem_ready) begin
                imem_ready = 1'b1;
                imem_rdata = mem_rdata;
            end
            BUSY_D: if (mem_ready) begin
                dmem_ready = 1'b1;
                dmem_rdata = mem_rdata;
            end
            default: ;
        endcase
    end

endmodule
